// File: rtl/rr_dispatch_pkg.sv
// Shared types and helpers for the round-robin node dispatcher.
// Latency: n/a (types only).  Backpressure: n/a.
package rr_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_NUM_NODES = 4;
    localparam int NODE_IDX_W    = $clog2(DEF_NUM_NODES);

    function automatic logic [31:0] onehot32(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/rr_node_dispatcher_pick.sv
// Rotating-priority picker: first set request at or after start_idx wins.
// Latency: combinational.  Backpressure: none; any=0 when no request is set.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(start_idx) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt_idx  = IW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_node_dispatcher.sv
// Streams an address window from memory and steers each word to node FIFOs round-robin.
// Latency: start -> first node_wr_en 2 cycles, then 1 word/cycle; done 2 cycles after last issue.
// Backpressure: stalls on node_full (almost-full); SKIP_FULL_EN skips full nodes instead.
module rr_node_dispatcher
    import rr_dispatch_pkg::*;
#(
    parameter int NUM_NODES  = DEF_NUM_NODES,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [NUM_NODES-1:0]  node_full,
    output logic [NUM_NODES-1:0]  node_wr_en,
    output logic [DATA_WIDTH-1:0] node_wdata,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int CW = ADDR_WIDTH + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [NUM_NODES-1:0]  wr_q, wr_d;

    logic [IW-1:0]         tgt;
    logic [NUM_NODES-1:0]  tgt_oh;
    logic                  can_issue;
    logic                  issue;
    logic [IW-1:0]         tgt_nxt;

`ifdef SKIP_FULL_EN
    rr_pick #(
        .N  (NUM_NODES),
        .IW (IW)
    ) u_pick (
        .req       (~node_full),
        .start_idx (ptr_q),
        .gnt       (tgt_oh),
        .gnt_idx   (tgt),
        .any       (can_issue)
    );
`else
    assign tgt       = ptr_q;
    assign tgt_oh    = NUM_NODES'(onehot32(int'(ptr_q)));
    assign can_issue = !node_full[ptr_q];
`endif

    assign issue   = (state_q == RUN) && can_issue;
    assign tgt_nxt = (tgt == IW'(NUM_NODES - 1)) ? '0 : tgt + IW'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        wr_d    = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = count;
                    ptr_d   = '0;
                    state_d = (count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - CW'(1);
                    ptr_d  = tgt_nxt;
                    wr_d   = tgt_oh;
                    if (rem_q == CW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A reset mid-transfer drops the in-flight write along with the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_rd_en  = issue;
    assign node_wr_en = wr_q;
    assign node_wdata = (|wr_q) ? mem_rdata : '0;
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_rr_node_dispatcher.sv
// Directed scoreboard bench for rr_node_dispatcher (default and SKIP_FULL_EN builds).
module tb_rr_node_dispatcher;

    localparam int NN = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_rdata = '0;
    logic [NN-1:0] node_full = '0;
    logic [NN-1:0] node_wr_en;
    logic [DW-1:0] node_wdata;
    logic          busy;
    logic          done;

    rr_node_dispatcher #(.NUM_NODES(NN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .count      (count),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .node_full  (node_full),
        .node_wr_en (node_wr_en),
        .node_wdata (node_wdata),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mdat(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mdat(mem_addr);
    end

    typedef struct {
        int            node;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passed = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int node_cnt[NN];
    int   mon_idx;
    exp_t mon_e;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) rd_cnt++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (node_wr_en != '0) begin
                wr_cnt++;
                if ($countones(node_wr_en) != 1) begin
                    chk("wr_onehot", $countones(node_wr_en), 1);
                end else begin
                    mon_idx = 0;
                    for (int i = 0; i < NN; i++) begin
                        if (node_wr_en[i]) begin
                            mon_idx = i;
                            node_cnt[i]++;
                        end
                    end
                    if (sb.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("wr_node", mon_idx, mon_e.node);
                        chk("wr_data", node_wdata, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic push_strict(input logic [AW-1:0] b, input int n);
        logic [AW-1:0] a;
        a = b;
        for (int k = 0; k < n; k++) begin
            sb.push_back('{node: k % NN, data: mdat(a)});
            a = a + 8'd1;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [AW-1:0] b, input logic [AW:0] n,
                           input logic [NN-1:0] fmask, input int fcyc, input int repulse,
                           input int exp_cyc);
        int c, rd0, wr0, dn0, bz0;
        bit got;
        rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt; bz0 = busy_cnt;
        base_addr = b; count = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; got = 1'b0;
        node_full = (fcyc >= 1) ? fmask : '0;
        while (!got && c < 2000) begin
            if (c == repulse) begin
                start = 1'b1; base_addr = 8'h55; count = 9'd3;
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                @(posedge clk); #1;
                start = 1'b0;
                c++;
                node_full = (c <= fcyc) ? fmask : '0;
            end
        end
        node_full = '0;
        chk({tag, "_done_cycle"}, got ? c : -1, exp_cyc);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, done_cnt - dn0, 1);
        chk({tag, "_reads"}, rd_cnt - rd0, n);
        chk({tag, "_writes"}, wr_cnt - wr0, n);
        chk({tag, "_busy_cycles"}, busy_cnt - bz0, exp_cyc - 1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc0[NN];
        int dn0;
        for (int i = 0; i < NN; i++) node_cnt[i] = 0;

        // Reset state
        #12;
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", node_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wdata", node_wdata, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic 8-word window
        push_strict(8'h10, 8);
        run_cmd("t1", 8'h10, 9'd8, '0, 0, 0, 10);

        // 2: address wrap past all-ones
        push_strict(8'hFE, 4);
        run_cmd("t2", 8'hFE, 9'd4, '0, 0, 0, 6);

        // 3: zero-length window
        run_cmd("t3", 8'h33, 9'd0, '0, 0, 0, 1);

        // 4: node 1 full for five cycles
`ifdef SKIP_FULL_EN
        begin
            int nodes[8] = '{0, 2, 3, 0, 2, 3, 0, 1};
            for (int k = 0; k < 8; k++)
                sb.push_back('{node: nodes[k], data: mdat(8'(8'h80 + k))});
        end
        run_cmd("t4", 8'h80, 9'd8, 4'b0010, 5, 0, 10);
`else
        push_strict(8'h80, 8);
        run_cmd("t4", 8'h80, 9'd8, 4'b0010, 5, 0, 14);
`endif

        // 5: asynchronous reset mid-run
        push_strict(8'h40, 2);
        dn0 = done_cnt;
        base_addr = 8'h40; count = 9'd16; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rd_en", mem_rd_en, 0);
        chk("t5_wr_en", node_wr_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_wdata", node_wdata, 0);
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_no_done", done_cnt - dn0, 0);
        chk("t5_sb_empty", sb.size(), 0);
        sb.delete();
        push_strict(8'h00, 4);
        run_cmd("t5b", 8'h00, 9'd4, '0, 0, 0, 6);

        // 6: full 256-word window with a start re-pulse mid-run
        for (int i = 0; i < NN; i++) nc0[i] = node_cnt[i];
        push_strict(8'h00, 256);
        run_cmd("t6", 8'h00, 9'd256, '0, 0, 100, 258);
        for (int i = 0; i < NN; i++) chk($sformatf("t6_node%0d_writes", i), node_cnt[i] - nc0[i], 64);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
